// File: rtl/gear_box.sv
// N-gear shifter with a clutch lockout counter; each accepted upshift is graded
// against the engine RPM sampled in the accept cycle.
module gear_box #(
    parameter int unsigned GEAR_W         = 3,
    parameter int unsigned MAX_GEAR       = 5,
    parameter int unsigned LOCKOUT_CYCLES = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned RPM_W          = 12,
    parameter int unsigned GOOD_LO        = 2000,
    parameter int unsigned PERFECT_LO     = 3000,
    parameter int unsigned PERFECT_HI     = 3500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reset_status,
    input  logic              shift_up,
    input  logic              shift_down,
    input  logic [RPM_W-1:0]  rpm,
    output logic [GEAR_W-1:0] gear,
    output logic              busy,
    output logic              shift_done,
    output logic [1:0]        shift_quality,
    output logic              rejected
);

    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [1:0] {
        Q_LATE    = 2'd0,
        Q_EARLY   = 2'd1,
        Q_GOOD    = 2'd2,
        Q_PERFECT = 2'd3
    } grade_t;

    localparam logic [GEAR_W-1:0] MAX_G     = GEAR_W'(MAX_GEAR);
    localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [RPM_W-1:0]  R_GOOD    = RPM_W'(GOOD_LO);
    localparam logic [RPM_W-1:0]  R_PLO     = RPM_W'(PERFECT_LO);
    localparam logic [RPM_W-1:0]  R_PHI     = RPM_W'(PERFECT_HI);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GEAR_W-1:0]  gear_q, gear_d;
    logic [GEAR_W-1:0]  target_q, target_d;
    grade_t             quality_q, quality_d;
    logic               done_q, done_d;
    logic               rej_q, rej_d;
    grade_t             grade;

    always_comb begin
        if (rpm < R_GOOD)      grade = Q_EARLY;
        else if (rpm < R_PLO)  grade = Q_GOOD;
        else if (rpm <= R_PHI) grade = Q_PERFECT;
        else                   grade = Q_LATE;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gear_d    = gear_q;
        target_d  = target_q;
        quality_d = quality_q;
        done_d    = 1'b0;
        rej_d     = 1'b0;
        if (reset_status) begin
            state_d  = IDLE;
            cnt_d    = '0;
            gear_d   = '0;
            target_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The cycle showing shift_done still counts as busy.
                    if (done_q) begin
                        rej_d = shift_up | shift_down;
                    end else if (shift_up && !shift_down) begin
                        if (gear_q < MAX_G) begin
                            state_d   = SHIFT;
                            cnt_d     = CNT_START;
                            target_d  = gear_q + 1'b1;
                            quality_d = grade;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end else if (shift_down && !shift_up) begin
                        if (gear_q != '0) begin
                            state_d  = SHIFT;
                            cnt_d    = CNT_START;
                            target_d = gear_q - 1'b1;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // shift_done wins on the commit edge so the two pulses never overlap.
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        gear_d  = target_q;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        rej_d = shift_up | shift_down;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gear_q    <= '0;
            target_q  <= '0;
            quality_q <= Q_LATE;
            done_q    <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gear_q    <= gear_d;
            target_q  <= target_d;
            quality_q <= quality_d;
            done_q    <= done_d;
            rej_q     <= rej_d;
        end
    end

    assign gear          = gear_q;
    assign busy          = (state_q == SHIFT);
    assign shift_done    = done_q;
    assign shift_quality = quality_q;
    assign rejected      = rej_q;

    a_gear_range: assert property (@(posedge clk) disable iff (!rst) gear_q <= MAX_G);

endmodule

// File: tb/tb_gear_box.sv
// Randomised and directed bench for gear_box against a per-edge behavioural model
// that tracks the gear, the edges left until a pending shift lands, and the last grade.
module tb_gear_box;

    localparam int MAXG = 5;
    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reset_status = 1'b0;
    logic        shift_up = 1'b0;
    logic        shift_down = 1'b0;
    logic [11:0] rpm = '0;
    logic [2:0]  gear;
    logic        busy;
    logic        shift_done;
    logic [1:0]  shift_quality;
    logic        rejected;

    gear_box #(
        .GEAR_W(3), .MAX_GEAR(MAXG), .LOCKOUT_CYCLES(LOCK), .CNT_W(8), .RPM_W(12),
        .GOOD_LO(2000), .PERFECT_LO(3000), .PERFECT_HI(3500)
    ) dut (
        .clk(clk), .rst(rst), .reset_status(reset_status),
        .shift_up(shift_up), .shift_down(shift_down), .rpm(rpm),
        .gear(gear), .busy(busy), .shift_done(shift_done),
        .shift_quality(shift_quality), .rejected(rejected)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: m_rem = edges still to go before the pending gear lands
    int m_gear = 0, m_rem = 0, m_tgt = 0, m_q = 0, m_done = 0, m_rej = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int grade_of(input int r);
        if (r < 2000) return 1;
        if (r < 3000) return 2;
        if (r <= 3500) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_gear = 0; m_rem = 0; m_tgt = 0; m_q = 0; m_done = 0; m_rej = 0;
    endtask

    task automatic model_edge(input bit up, input bit dn, input bit rs, input int r);
        int prev_done;
        prev_done = m_done;
        m_done = 0;
        m_rej  = 0;
        if (rs) begin
            m_gear = 0; m_rem = 0; m_tgt = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_gear = m_tgt;
                m_done = 1;
            end else begin
                m_rej = int'(up || dn);
            end
        end else if (prev_done != 0) begin
            m_rej = int'(up || dn);
        end else if (up && !dn) begin
            if (m_gear < MAXG) begin
                m_tgt = m_gear + 1; m_rem = LOCK; m_q = grade_of(r);
            end else m_rej = 1;
        end else if (dn && !up) begin
            if (m_gear > 0) begin
                m_tgt = m_gear - 1; m_rem = LOCK;
            end else m_rej = 1;
        end
    endtask

    task automatic check_all();
        check("gear", int'(gear), m_gear);
        check("busy", int'(busy), int'(m_rem > 0));
        check("shift_done", int'(shift_done), m_done);
        check("rejected", int'(rejected), m_rej);
        check("quality", int'(shift_quality), m_q);
    endtask

    task automatic step(input bit up, input bit dn, input bit rs, input int r);
        @(negedge clk);
        shift_up = up; shift_down = dn; reset_status = rs; rpm = 12'(r);
        @(posedge clk);
        model_edge(up, dn, rs, r);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1000);
    endtask

    int sweep_rpm [5] = '{1999, 2000, 3499, 3500, 3501};
    int sweep_q   [5] = '{1, 2, 3, 3, 0};
    int edge_rpm  [8] = '{0, 1999, 2000, 2999, 3000, 3500, 3501, 4095};

    initial begin
        #12;
        check("reset_gear", int'(gear), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_quality", int'(shift_quality), 0);
        @(negedge clk) rst = 1'b1;

        // upshift timing and grade
        step(1'b1, 1'b0, 1'b0, 3200);
        for (int i = 1; i <= LOCK; i++) begin
            check("busy_during_lockout", int'(busy), 1);
            step(1'b0, 1'b0, 1'b0, 3200);
        end
        check("gear_after_lockout", int'(gear), 1);
        check("done_after_lockout", int'(shift_done), 1);
        check("quality_perfect", int'(shift_quality), 3);
        idle(1);

        // grading sweep from gear 0 up to MAX
        step(1'b0, 1'b0, 1'b1, 0);
        foreach (sweep_rpm[i]) begin
            step(1'b1, 1'b0, 1'b0, sweep_rpm[i]);
            idle(LOCK + 1);
            check("sweep_quality", int'(shift_quality), sweep_q[i]);
        end
        check("gear_at_max", int'(gear), MAXG);

        // limits
        step(1'b1, 1'b0, 1'b0, 3200);
        check("reject_up_at_max", int'(rejected), 1);
        check("gear_held_max", int'(gear), MAXG);
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        check("reject_down_at_zero", int'(rejected), 1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 2500); idle(LOCK + 1);
        end
        step(1'b1, 1'b1, 1'b0, 2500);
        check("both_no_reject", int'(rejected), 0);
        check("both_gear_held", int'(gear), 2);

        // busy rejection: second pulse two cycles later
        step(1'b1, 1'b0, 1'b0, 1500);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 3800);
        check("busy_reject", int'(rejected), 1);
        idle(LOCK + 1);
        check("busy_gear_plus_one", int'(gear), 3);
        check("busy_quality_first", int'(shift_quality), 1);

        // reset_status one cycle after accept
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        check("rs_gear", int'(gear), 0);
        check("rs_busy", int'(busy), 0);
        idle(LOCK + 2);
        check("rs_quality_held", int'(shift_quality), 1);

        // async reset mid-shift at gear 2 -> 3
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 2500); idle(LOCK + 1);
        end
        step(1'b1, 1'b0, 1'b0, 2500);
        idle(1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("async_gear", int'(gear), 0);
        check("async_busy", int'(busy), 0);
        @(negedge clk) rst = 1'b1;
        idle(LOCK + 2);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int v, r;
            bit up, dn, rs;
            v  = int'($urandom_range(0, 7));
            up = (v < 3) || (v == 7);
            dn = (v == 3) || (v == 4) || (v == 7);
            rs = ($urandom_range(0, 59) == 0);
            r  = ($urandom_range(0, 1) == 0) ? edge_rpm[$urandom_range(0, 7)]
                                             : int'($urandom_range(0, 4095));
            step(up, dn, rs, r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
